// File: rtl/accel_spi_reader.sv
// SPI master for the ADXL362: enables measurement mode once after reset, then
// burst-reads X/Y at the sample rate and re-centres them as 9-bit tilt values.
module accel_spi_reader #(
    parameter int CLK_FREQUENCY_HZ    = 100000000,
    parameter int SCLK_FREQUENCY_HZ   = 1000000,
    parameter int SAMPLE_FREQUENCY_HZ = 100,
    parameter int STARTUP_CYCLES      = 1000000,
    parameter int SIMULATE            = 0,
    parameter int SIMULATE_SAMPLE_CNT = 200
) (
    input  logic       clk,
    input  logic       reset,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [8:0] accelX_OUT,
    output logic [8:0] accelY_OUT,
    output logic       accel_valid,
    output logic       init_done
);

    localparam int HALF          = (SIMULATE != 0) ? 2 : CLK_FREQUENCY_HZ / (2 * SCLK_FREQUENCY_HZ);
    localparam int STARTUP       = (SIMULATE != 0) ? 16 : STARTUP_CYCLES;
    localparam int SAMPLE_PERIOD = (SIMULATE != 0) ? SIMULATE_SAMPLE_CNT : CLK_FREQUENCY_HZ / SAMPLE_FREQUENCY_HZ;
    localparam int GAP_CYCLES    = 2 * HALF;
    localparam int CNT_W         = $clog2(((STARTUP > GAP_CYCLES) ? STARTUP : GAP_CYCLES) + 1);
    localparam int HALF_W        = $clog2(HALF + 1);
    localparam int SMP_W         = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [CNT_W-1:0]  STARTUP_LAST = CNT_W'(STARTUP - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST    = HALF_W'(HALF - 1);
    localparam logic [SMP_W-1:0]  SAMPLE_LAST  = SMP_W'(SAMPLE_PERIOD - 1);

    // Outgoing frames are left-aligned so both transfers shift from bit 47.
    localparam logic [47:0] INIT_FRAME = {8'h0A, 8'h2D, 8'h02, 24'h000000};
    localparam logic [47:0] READ_FRAME = {8'h0B, 8'h0E, 32'h00000000};

    typedef enum logic [2:0] {
        WAIT_START,
        INIT_XFER,
        GAP,
        IDLE,
        RD_XFER,
        CONVERT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [HALF_W-1:0]   half_cnt;
    logic [SMP_W-1:0]    sample_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          frame_bits;
    logic [47:0]         shift_out;
    logic [31:0]         shift_in;
    logic                pending;
    logic                tick;
    logic [7:0]          unused_status;

    // Upper nibbles of XH/YH only carry sign extension and are not needed.
    assign unused_status = {shift_in[23:20], shift_in[7:4]};
    assign tick          = (sample_cnt == SAMPLE_LAST);
    assign frame_bits    = (state == INIT_XFER) ? 6'd24 : 6'd48;

    // 12-bit reading -> divide by 4, saturate to 9-bit signed, then offset by 256.
    function automatic logic [8:0] to_tilt(input logic [7:0] lo, input logic [3:0] hi);
        logic signed [11:0] raw;
        logic signed [11:0] sh;
        raw = {hi, lo};
        sh  = raw >>> 2;
        if (sh > 12'sd255)
            to_tilt = 9'd511;
        else if (sh < -12'sd256)
            to_tilt = 9'd0;
        else
            to_tilt = {~sh[8], sh[7:0]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sample_cnt <= '0;
        else if (tick)
            sample_cnt <= '0;
        else
            sample_cnt <= sample_cnt + SMP_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_START;
            cnt         <= '0;
            half_cnt    <= '0;
            bit_cnt     <= '0;
            shift_out   <= '0;
            shift_in    <= '0;
            pending     <= 1'b0;
            spi_sclk    <= 1'b0;
            spi_cs_n    <= 1'b1;
            spi_mosi    <= 1'b0;
            accelX_OUT  <= 9'd256;
            accelY_OUT  <= 9'd256;
            accel_valid <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            accel_valid <= 1'b0;
            if (tick && init_done)
                pending <= 1'b1;

            case (state)
                WAIT_START: begin
                    if (cnt == STARTUP_LAST) begin
                        cnt       <= '0;
                        half_cnt  <= '0;
                        bit_cnt   <= '0;
                        shift_out <= INIT_FRAME;
                        spi_mosi  <= INIT_FRAME[47];
                        spi_cs_n  <= 1'b0;
                        state     <= INIT_XFER;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Shared bit engine: rise samples MISO, fall advances MOSI.
                INIT_XFER, RD_XFER: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end else begin
                        half_cnt <= '0;
                        if (spi_sclk) begin
                            spi_sclk  <= 1'b0;
                            bit_cnt   <= bit_cnt + 6'd1;
                            shift_out <= {shift_out[46:0], 1'b0};
                            spi_mosi  <= shift_out[46];
                        end else if (bit_cnt != frame_bits) begin
                            spi_sclk <= 1'b1;
                            shift_in <= {shift_in[30:0], spi_miso};
                        end else begin
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            cnt      <= '0;
                            if (state == INIT_XFER) begin
                                init_done <= 1'b1;
                                state     <= GAP;
                            end else begin
                                state <= CONVERT;
                            end
                        end
                    end
                end

                CONVERT: begin
                    accelX_OUT  <= to_tilt(shift_in[31:24], shift_in[19:16]);
                    accelY_OUT  <= to_tilt(shift_in[15:8], shift_in[3:0]);
                    accel_valid <= 1'b1;
                    cnt         <= '0;
                    state       <= GAP;
                end

                GAP: begin
                    if (cnt == GAP_LAST)
                        state <= IDLE;
                    else
                        cnt <= cnt + CNT_W'(1);
                end

                IDLE: begin
                    if (pending) begin
                        pending   <= tick;
                        half_cnt  <= '0;
                        bit_cnt   <= '0;
                        shift_out <= READ_FRAME;
                        spi_mosi  <= READ_FRAME[47];
                        spi_cs_n  <= 1'b0;
                        state     <= RD_XFER;
                    end
                end

                default: state <= WAIT_START;
            endcase
        end
    end

endmodule
